frame_mark_tx: RTL and testbench

//  Serial frame transmitter for the 3-slot mark detector FSM. Accepts message bits over a

---
 rtl/frame_mark_tx.sv | 122 ++++++++++++
 tb/tb_frame_mark_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_mark_tx.sv
// frame_mark_tx
//   Serial frame transmitter feeding the 3-slot mark detector. Message bits
//   arrive over a valid/ready handshake into a small FIFO. Each bit is sent
//   as one 3-cycle frame (bit A, bit B, pad) on a registered 1-bit line.
//   A '1' becomes the mark frame (1,0,0). A '0' becomes (0,0,0) or (1,1,0),
//   selected by ZERO_ENC. Neither '0' frame makes the detector fire.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      in_bit is valid
//   in_bit      in   1      message bit
//   in_ready    out  1      FIFO not full
//   out         out  1      registered serial line
//   slot        out  2      0=bit A, 1=bit B, 2=pad, 3=guard
//   frame_start out  1      high in slot 0
//   busy        out  1      FIFO non-empty or current frame carries data
//   mark_cnt    out  CNT_W  mark frames sent, wrapping
module frame_mark_tx #(
    parameter int unsigned DEPTH    = 4,
    parameter bit          ZERO_ENC = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out,
    output logic [1:0]       slot,
    output logic             frame_start,
    output logic             busy,
    output logic [CNT_W-1:0] mark_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S0    = 2'd0,
        S1    = 2'd1,
        S2    = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, push, pop, load, head;
    logic             cur_valid, cur_bit;
    logic             out_nx, mark_inc;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Frame load on every edge entering S0. A bit pushed on this very edge is
    // not yet visible (empty is registered), so it waits for the next frame.
    assign load     = (state == GUARD) || (state == S2);
    assign pop      = load && !empty;
    assign push     = in_valid && !full;
    assign mark_inc = (state == S1) && cur_valid && cur_bit;

    always_comb begin
        state_nx = state;
        out_nx   = 1'b0;
        case (state)
            GUARD, S2: begin
                state_nx = S0;
                out_nx   = pop && (head || ZERO_ENC);
            end
            S0: begin
                state_nx = S1;
                out_nx   = cur_valid && !cur_bit && ZERO_ENC;
            end
            S1: begin
                state_nx = S2;
                out_nx   = 1'b0;
            end
            default: begin
                state_nx = GUARD;
                out_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GUARD;
            out       <= 1'b0;
            cur_valid <= 1'b0;
            cur_bit   <= 1'b0;
            mark_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem       <= '0;
        end else begin
            state <= state_nx;
            out   <= out_nx;
            if (load) begin
                cur_valid <= pop;
                cur_bit   <= pop && head;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= in_bit;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (mark_inc) begin
                mark_cnt <= mark_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = !full;
    assign slot        = state;
    assign frame_start = (state == S0);
    assign busy        = !empty || cur_valid;

endmodule

// File: tb/tb_frame_mark_tx.sv
module tb_frame_mark_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;

    logic       in_ready_a, out_a, frame_start_a, busy_a;
    logic [1:0] slot_a;
    logic [7:0] mark_cnt_a;
    logic       in_ready_b, out_b, frame_start_b, busy_b;
    logic [1:0] slot_b;
    logic [1:0] mark_cnt_b;

    always #5 clk = ~clk;

    frame_mark_tx #(.DEPTH(4), .ZERO_ENC(1'b0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_a), .out(out_a), .slot(slot_a),
        .frame_start(frame_start_a), .busy(busy_a), .mark_cnt(mark_cnt_a)
    );

    frame_mark_tx #(.DEPTH(4), .ZERO_ENC(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_b), .out(out_b), .slot(slot_b),
        .frame_start(frame_start_b), .busy(busy_b), .mark_cnt(mark_cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted bits with the index of the edge that accepted them.
    bit qb[$];
    int qe[$];
    int edge_cnt = 0;
    int push_cnt = 0;
    bit cur_data = 1'b0;
    bit cur_b    = 1'b0;
    int marks    = 0;
    int prev_slot = 3;
    bit det_a_a, det_b_a, det_a_b, det_b_b;
    int pulse_a = 0;
    int pulse_b = 0;
    bit full_seen = 1'b0;

    // Acceptance modelled from the bench's own FIFO occupancy.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst_n && in_valid && qb.size() < 4) begin
            qb.push_back(in_bit);
            qe.push_back(edge_cnt);
            push_cnt++;
        end
    end

    // Monitor: every negedge, compare both DUTs against the model.
    always @(negedge clk) begin
        int  es;
        bit  ea, eb, ebusy;
        if (!rst_n) begin
            chk("rst_out_a", out_a, 0);           chk("rst_out_b", out_b, 0);
            chk("rst_slot_a", slot_a, 3);         chk("rst_slot_b", slot_b, 3);
            chk("rst_fs_a", frame_start_a, 0);    chk("rst_busy_a", busy_a, 0);
            chk("rst_busy_b", busy_b, 0);         chk("rst_rdy_a", in_ready_a, 1);
            chk("rst_rdy_b", in_ready_b, 1);      chk("rst_cnt_a", mark_cnt_a, 0);
            chk("rst_cnt_b", mark_cnt_b, 0);
            qb.delete(); qe.delete();
            cur_data = 1'b0; cur_b = 1'b0; marks = 0; prev_slot = 3;
        end else begin
            es = (prev_slot >= 2) ? 0 : prev_slot + 1;
            chk("slot_a", slot_a, es);
            chk("slot_b", slot_b, es);
            if (es == 0) begin
                if (qb.size() > 0 && qe[0] < edge_cnt) begin
                    cur_data = 1'b1;
                    cur_b    = qb.pop_front();
                    void'(qe.pop_front());
                end else begin
                    cur_data = 1'b0;
                end
            end
            case (es)
                0:       begin ea = cur_data && cur_b; eb = cur_data;           end
                1:       begin ea = 1'b0;              eb = cur_data && !cur_b; end
                default: begin ea = 1'b0;              eb = 1'b0;               end
            endcase
            chk("out_a", out_a, ea);
            chk("out_b", out_b, eb);
            chk("fs_a", frame_start_a, (es == 0) ? 1 : 0);
            chk("fs_b", frame_start_b, (es == 0) ? 1 : 0);
            if (es == 2 && cur_data && cur_b) marks++;
            chk("cnt_a", mark_cnt_a, marks % 256);
            chk("cnt_b", mark_cnt_b, marks % 4);
            ebusy = cur_data || (qb.size() != 0);
            chk("busy_a", busy_a, ebusy);
            chk("busy_b", busy_b, ebusy);
            chk("rdy_a", in_ready_a, (qb.size() < 4) ? 1 : 0);
            chk("rdy_b", in_ready_b, (qb.size() < 4) ? 1 : 0);
            // Paired detector model: A at end of S0, B at end of S1, pulse in S2.
            if (es == 0) begin det_a_a = out_a; det_a_b = out_b; end
            if (es == 1) begin det_b_a = out_a; det_b_b = out_b; end
            if (es == 2) begin
                if (det_a_a && !det_b_a) pulse_a++;
                if (det_a_b && !det_b_b) pulse_b++;
            end
            prev_slot = es;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input bit b);
        int n0;
        n0 = push_cnt;
        in_valid = 1'b1;
        in_bit   = b;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (in_ready_a == 1'b0) full_seen = 1'b1;
            if (push_cnt != n0) break;
        end
        if (push_cnt == n0) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset: guard then empty frames.
        idle(9);
        chk("t1_pulse_a", pulse_a, 0);

        // Single mark.
        send(1'b1);
        idle(8);
        chk("t2_pulse_a", pulse_a, 1);
        chk("t2_cnt_a", mark_cnt_a, 1);
        chk("t2_cnt_b", mark_cnt_b, 1);

        // Single zero: no pulse on either encoding.
        send(1'b0);
        idle(8);
        chk("t3_pulse_a", pulse_a, 1);
        chk("t3_pulse_b", pulse_b, 1);
        chk("t3_cnt_a", mark_cnt_a, 1);

        // Back-to-back stream long enough to fill the FIFO.
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        idle(25);
        chk("t4_full_seen", full_seen, 1);
        chk("t4_cnt_a", mark_cnt_a, 5);
        chk("t4_cnt_b", mark_cnt_b, 1);
        chk("t4_pulse_a", pulse_a, 5);
        chk("t4_pulse_b", pulse_b, 5);

        // Reset during S1 of a mark frame with more bits queued.
        send(1'b1); send(1'b1); send(1'b1);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (slot_a == 2'd1 && cur_data && cur_b) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_found_s1", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_out_a", out_a, 0);
        chk("t5_slot_a", slot_a, 3);
        chk("t5_cnt_a", mark_cnt_a, 0);
        chk("t5_cnt_b", mark_cnt_b, 0);
        chk("t5_rdy_a", in_ready_a, 1);
        chk("t5_busy_a", busy_a, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(9);
        chk("t5_pulse_a", pulse_a, 5);

        // Counter wrap on the 2-bit instance: 1,2,3,0,1.
        for (int i = 0; i < 5; i++) send(1'b1);
        idle(20);
        chk("t6_cnt_a", mark_cnt_a, 5);
        chk("t6_cnt_b", mark_cnt_b, 1);
        chk("t6_pulse_a", pulse_a, 10);
        chk("t6_pulse_b", pulse_b, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
